// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: state encoding,
// ALU control codes and the set of control codes the ALU does not define.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    // bit n set => control code n is illegal (codes 3, 4, 5)
    localparam logic [7:0] ILLEGAL_OP_MASK = 8'b0011_1000;

    function automatic logic is_illegal_op(input logic [2:0] op);
        return ILLEGAL_OP_MASK[op];
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Issues one command at a time to an external ALU, waits SETTLE_CYCLES edges,
// captures the result with locally derived flags and holds it until consumed.
//
// state | meaning
// IDLE  | ready for a command; cmd_ready=1
// EXEC  | operands driven to the ALU, settle counter running down
// DONE  | result captured; rsp_valid=1 until rsp_ready
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctr,
    input  logic [31:0] alu_res,
    input  logic        alu_co,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_res,
    output logic        rsp_co,
    output logic        rsp_ovf,
    output logic        rsp_zero,
    output logic        rsp_illegal,
    output logic [15:0] op_count
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic       load;
    logic       capture;
    logic       retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        capture   = 1'b0;
        retire    = 1'b0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load      = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (settle_cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctr     <= '0;
            settle_cnt  <= '0;
            rsp_res     <= '0;
            rsp_co      <= 1'b0;
            rsp_ovf     <= 1'b0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            if (load) begin
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
                alu_ctr    <= cmd_op;
                settle_cnt <= SETTLE_LOAD;
            end else if (state == EXEC && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            // zero flag is registered so it reads 0 out of reset like the other flags
            if (capture) begin
                rsp_res     <= alu_res;
                rsp_co      <= alu_co;
                rsp_ovf     <= alu_overflow;
                rsp_zero    <= (alu_res == 32'd0);
                rsp_illegal <= is_illegal_op(alu_ctr);
            end
            if (retire) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: two sequencers (settle 1 and settle 4), each driving its own
// behavioural ALU, checked against a reference model of the expected responses.
module tb_alu_op_sequencer;

    localparam int unsigned SETTLE0 = 1;
    localparam int unsigned SETTLE1 = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk;
    logic        rst;
    logic        cmd_valid    [2];
    logic        cmd_ready    [2];
    logic [31:0] cmd_a        [2];
    logic [31:0] cmd_b        [2];
    logic [2:0]  cmd_op       [2];
    logic [31:0] alu_a        [2];
    logic [31:0] alu_b        [2];
    logic [2:0]  alu_ctr      [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [31:0] rsp_res      [2];
    logic        rsp_co       [2];
    logic        rsp_ovf      [2];
    logic        rsp_zero     [2];
    logic        rsp_illegal  [2];
    logic [15:0] op_count     [2];
    logic [15:0] exp_cnt      [2];

    int n_checks = 0;
    int n_pass   = 0;

    // external ALU as seen by the sequencer: {co, ovf, res}
    function automatic logic [33:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        logic [32:0] sum;
        logic [31:0] res;
        logic        co;
        logic        ovf;
        sum = '0;
        co  = 1'b0;
        ovf = 1'b0;
        case (op)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd2: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[31:0];
                co  = sum[32];
                ovf = (a[31] == b[31]) && (res[31] != a[31]);
            end
            3'd6: begin
                sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
                res = sum[31:0];
                co  = sum[32];
                ovf = (a[31] != b[31]) && (res[31] != a[31]);
            end
            3'd7: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: res = 32'hA5A5A5A5;
        endcase
        return {co, ovf, res};
    endfunction

    // expected response: {illegal, zero, ovf, co, res}
    function automatic logic [35:0] ref_rsp(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        longint ua, ub, sa, sb, s;
        logic [31:0] res;
        logic co, ovf, ill;
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        co  = 1'b0;
        ovf = 1'b0;
        case (op)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd2: begin
                res = 32'(ua + ub);
                co  = (ua + ub) > 64'sd4294967295;
                s   = sa + sb;
                ovf = (s > SMAX) || (s < SMIN);
            end
            3'd6: begin
                res = 32'(ua - ub);
                co  = (ua >= ub);
                s   = sa - sb;
                ovf = (s > SMAX) || (s < SMIN);
            end
            3'd7: res = (sa < sb) ? 32'd1 : 32'd0;
            default: res = 32'hA5A5A5A5;
        endcase
        ill = (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        return {ill, (res == 32'd0), ovf, co, res};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [33:0] alu_out;
        assign alu_out = alu_model(alu_a[gi], alu_b[gi], alu_ctr[gi]);

        alu_op_sequencer #(.SETTLE_CYCLES(gi == 0 ? SETTLE0 : SETTLE1)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .cmd_valid    (cmd_valid[gi]),
            .cmd_ready    (cmd_ready[gi]),
            .cmd_a        (cmd_a[gi]),
            .cmd_b        (cmd_b[gi]),
            .cmd_op       (cmd_op[gi]),
            .alu_a        (alu_a[gi]),
            .alu_b        (alu_b[gi]),
            .alu_ctr      (alu_ctr[gi]),
            .alu_res      (alu_out[31:0]),
            .alu_co       (alu_out[33]),
            .alu_overflow (alu_out[32]),
            .rsp_valid    (rsp_valid[gi]),
            .rsp_ready    (rsp_ready[gi]),
            .rsp_res      (rsp_res[gi]),
            .rsp_co       (rsp_co[gi]),
            .rsp_ovf      (rsp_ovf[gi]),
            .rsp_zero     (rsp_zero[gi]),
            .rsp_illegal  (rsp_illegal[gi]),
            .op_count     (op_count[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int settle_of(input int k);
        return (k == 0) ? int'(SETTLE0) : int'(SETTLE1);
    endfunction

    task automatic check_idle_reset(input int k);
        chk("rst_cmd_ready", cmd_ready[k], 1);
        chk("rst_rsp_valid", rsp_valid[k], 0);
        chk("rst_alu", {alu_a[k], alu_ctr[k]}, 0);
        chk("rst_alu_b", alu_b[k], 0);
        chk("rst_rsp", {rsp_res[k], rsp_co[k], rsp_ovf[k], rsp_zero[k], rsp_illegal[k]}, 0);
        chk("rst_op_count", op_count[k], 0);
    endtask

    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input int hold);
        logic [35:0] exp;
        int lat;
        exp = ref_rsp(a, b, op);
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready[k], 1);
        cmd_a[k] = a;
        cmd_b[k] = b;
        cmd_op[k] = op;
        cmd_valid[k] = 1'b1;
        @(negedge clk);
        cmd_valid[k] = 1'b0;
        chk("alu_a", alu_a[k], a);
        chk("alu_b", alu_b[k], b);
        chk("alu_ctr", alu_ctr[k], op);
        chk("cmd_ready_busy", cmd_ready[k], 0);
        lat = 0;
        while (!rsp_valid[k] && lat < 40) begin
            cmd_a[k] = $urandom;
            cmd_b[k] = $urandom;
            cmd_op[k] = 3'($urandom);
            cmd_valid[k] = 1'($urandom_range(0, 1));
            rsp_ready[k] = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        rsp_ready[k] = 1'b0;
        chk("latency", lat, settle_of(k));
        chk("rsp_res", rsp_res[k], exp[31:0]);
        chk("rsp_co", rsp_co[k], exp[32]);
        chk("rsp_ovf", rsp_ovf[k], exp[33]);
        chk("rsp_zero", rsp_zero[k], exp[34]);
        chk("rsp_illegal", rsp_illegal[k], exp[35]);
        for (int i = 0; i < hold; i++) begin
            cmd_a[k] = $urandom;
            cmd_valid[k] = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_rsp", {rsp_illegal[k], rsp_zero[k], rsp_ovf[k], rsp_co[k], rsp_res[k]}, exp);
            chk("hold_valid", rsp_valid[k], 1);
            chk("hold_cmd_ready", cmd_ready[k], 0);
        end
        chk("alu_a_stable", alu_a[k], a);
        cmd_valid[k] = 1'b0;
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        exp_cnt[k] = exp_cnt[k] + 16'd1;
        chk("rsp_valid_drop", rsp_valid[k], 0);
        chk("cmd_ready_back", cmd_ready[k], 1);
        chk("op_count", op_count[k], exp_cnt[k]);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int lat;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0;
            rsp_ready[k] = 1'b0;
            cmd_a[k] = '0;
            cmd_b[k] = '0;
            cmd_op[k] = '0;
            exp_cnt[k] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) check_idle_reset(k);

        for (int k = 0; k < 2; k++) begin
            run_op(k, 32'd5, 32'd7, 3'd2, 0);
            run_op(k, 32'd3, 32'd3, 3'd6, 0);
            run_op(k, 32'd2, 32'd9, 3'd7, 0);
            run_op(k, 32'hFFFFFFFF, 32'd1, 3'd7, 0);
            run_op(k, 32'hFFFFFFFF, 32'd1, 3'd2, 0);
            run_op(k, 32'h7FFFFFFF, 32'd1, 3'd2, 0);
            run_op(k, 32'h1234, 32'h5678, 3'd3, 0);
            run_op(k, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd0, 10);
        end

        // op_count wrap from all-ones
        @(negedge clk);
        force g_dut[0].u_dut.op_count = 16'hFFFF;
        @(negedge clk);
        release g_dut[0].u_dut.op_count;
        exp_cnt[0] = 16'hFFFF;
        chk("preset_count", op_count[0], 16'hFFFF);
        run_op(0, 32'd1, 32'd1, 3'd1, 0);

        // reset on the second EXEC edge of the settle-4 instance
        @(negedge clk);
        cmd_a[1] = 32'hDEAD;
        cmd_b[1] = 32'h1;
        cmd_op[1] = 3'd2;
        cmd_valid[1] = 1'b1;
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt[0] = '0;
        exp_cnt[1] = '0;
        for (int k = 0; k < 2; k++) check_idle_reset(k);
        repeat (6) @(negedge clk);
        chk("abort_no_rsp", rsp_valid[1], 0);
        chk("abort_count", op_count[1], 0);

        // reset wins over a completing handshake
        run_op(0, 32'd10, 32'd4, 3'd6, 0);
        @(negedge clk);
        cmd_a[0] = 32'd8;
        cmd_b[0] = 32'd8;
        cmd_op[0] = 3'd2;
        cmd_valid[0] = 1'b1;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        lat = 0;
        while (!rsp_valid[0] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("prio_latency", lat, SETTLE0);
        rsp_ready[0] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rsp_ready[0] = 1'b0;
        exp_cnt[0] = '0;
        exp_cnt[1] = '0;
        chk("prio_count", op_count[0], 0);
        chk("prio_valid", rsp_valid[0], 0);
        chk("prio_ready", cmd_ready[0], 1);

        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < 2; k++) begin
                ra = $urandom;
                rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                run_op(k, ra, rb, 3'($urandom), $urandom_range(0, 3));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst; rst is synchronous and active-high.
REQ-002 Parameter SETTLE_CYCLES, default 1, SHALL set the number of clk edges the ALU is given to settle; the legal range is 1..15.
REQ-003 clk  in  1  system clock, rising-edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cmd_valid  in  1  command present; cmd_ready  out  1  sequencer can accept.
REQ-006 cmd_a  in  32  operand A; cmd_b  in  32  operand B; cmd_op  in  3  ALU control code.
REQ-007 alu_a  out  32, alu_b  out  32, alu_ctr  out  3  registered operands and control driven to the external ALU.
REQ-008 alu_res  in  32, alu_co  in  1, alu_overflow  in  1  ALU results sampled back.
REQ-009 rsp_valid  out  1  result present; rsp_ready  in  1  consumer accepts.
REQ-010 rsp_res  out  32, rsp_co  out  1, rsp_ovf  out  1, rsp_zero  out  1, rsp_illegal  out  1  captured result and flags.
REQ-011 op_count  out  16  count of completed responses.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-013 In IDLE, cmd_ready SHALL be 1; in EXEC and DONE, cmd_ready SHALL be 0.
REQ-014 On an edge in IDLE with cmd_valid=1, the block SHALL latch cmd_a/cmd_b/cmd_op into alu_a/alu_b/alu_ctr, load the settle counter with SETTLE_CYCLES-1, and enter EXEC.
REQ-015 alu_a, alu_b and alu_ctr SHALL hold stable from the accept edge until the next accept edge.
REQ-016 In EXEC, the counter SHALL decrement each edge; on the edge where it equals 0, the block SHALL capture alu_res, alu_co and alu_overflow into the rsp_* registers and enter DONE.
REQ-017 Latency SHALL be exactly SETTLE_CYCLES edges from the accept edge to the first cycle with rsp_valid=1.
REQ-018 rsp_zero SHALL be computed locally as (captured rsp_res == 0); it SHALL NOT depend on any ALU zero output.
REQ-019 rsp_illegal SHALL be 1 when the latched op is 3, 4 or 5, and 0 otherwise; illegal ops SHALL still execute and return the ALU's value.
REQ-020 In DONE, rsp_valid SHALL be 1, and all rsp_* outputs SHALL be stable until the handshake completes.
REQ-021 On an edge in DONE with rsp_ready=1, the block SHALL enter IDLE and increment op_count; rsp_valid SHALL be 0 in the following cycle.
REQ-022 op_count SHALL wrap from 16'hFFFF to 0.
REQ-023 There is no same-cycle response and accept: a new command SHALL be accepted no earlier than the cycle after returning to IDLE.
REQ-024 cmd_valid in EXEC or DONE SHALL be ignored; cmd_* changes there SHALL NOT affect alu_* or rsp_*.
REQ-025 rsp_ready asserted outside DONE SHALL have no effect.

Reset
REQ-026 While rst=1 at an edge, the state SHALL become IDLE and all outputs SHALL become 0 (alu_*, rsp_*, op_count, rsp_valid), except cmd_ready, which SHALL be 1 after the reset edge.
REQ-027 Reset during EXEC or DONE SHALL abort the operation, produce no response and not increment op_count.
REQ-028 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-029 The shared package alu_seq_pkg SHALL hold the state encoding (IDLE=0, EXEC=1, DONE=2), the op codes (AND=0, OR=1, ADD=2, SUB=6, SLT=7) and the illegal-op set {3,4,5}.
REQ-030 The block SHALL contain no sub-module; the ALU SHALL be instantiated at the parent level and wired to the alu_* ports.

Verification
REQ-031 ADD: A=5, B=7, op=2, SETTLE_CYCLES=1 -> rsp_valid 1 edge after accept, with res=12, co=0, zero=0, illegal=0.
REQ-032 SUB: A=3, B=3, op=6 -> res=0, zero=1, co=1, ovf=0; SLT: A=2, B=9, op=7 -> res=1.
REQ-033 Illegal op: op=3 with an ALU model returning 32'hA5A5A5A5 -> rsp_res=32'hA5A5A5A5, rsp_illegal=1, op_count increments.
REQ-034 Backpressure: hold rsp_ready=0 for 10 cycles while toggling cmd_a and cmd_valid -> rsp_* unchanged, cmd_ready=0; rsp_ready=1 -> IDLE next cycle.
REQ-035 Reset mid-EXEC with SETTLE_CYCLES=4, rst on the 2nd EXEC edge -> no rsp_valid, op_count=0, cmd_ready=1.
REQ-036 Counter wrap: preset op_count to 16'hFFFF, complete one transaction -> op_count=0.
